// File: rtl/gp_data_reg_pkg.sv
// Shared definitions for the gp_data_reg storage register.
// The parity helper is also used by the register testers' scoreboards.
// The op encoding names the per-cycle operation that benches apply to the register.
package gp_data_reg_pkg;

    localparam int DEF_DWIDTH = 8;
    localparam int MAX_DWIDTH = 64;

    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_LOAD = 2'd1,
        OP_CLR  = 2'd2
    } op_e;

    // Even-parity bit (XOR of all bits) of a value.
    // Narrower values are zero-extended by the caller; the zero bits do not change the result.
    function automatic logic even_par(input logic [MAX_DWIDTH-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/gp_data_reg_par.sv
// Parity generator and checker for gp_data_reg.
// This module is instantiated only when GP_DATA_REG_PARITY_EN is defined.
// par is registered alongside q from the same next-state value, so the two always agree.
// par_err pulses for one cycle after a load whose d_par disagrees with the parity of d.
module gp_data_reg_par
    import gp_data_reg_pkg::*;
#(
    parameter int                DWIDTH  = DEF_DWIDTH,
    parameter logic [DWIDTH-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DWIDTH-1:0] q_next,
    input  logic [DWIDTH-1:0] d,
    input  logic              d_par,
    output logic              par,
    output logic              par_err
);

    localparam logic RST_PAR = ^RST_VAL;

    logic [MAX_DWIDTH-1:0] q_ext;
    logic [MAX_DWIDTH-1:0] d_ext;
    logic                  par_d;
    logic                  par_q;
    logic                  par_err_d;
    logic                  par_err_q;

    // Zero-extend the operands to the helper's width, then derive the stored parity and the load check.
    always_comb begin
        q_ext              = '0;
        d_ext              = '0;
        q_ext[DWIDTH-1:0]  = q_next;
        d_ext[DWIDTH-1:0]  = d;
        par_d              = even_par(q_ext);
        par_err_d          = load & (d_par ^ even_par(d_ext));
    end

    // Register the parity and the error pulse on the same edge as q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q     <= RST_PAR;
            par_err_q <= 1'b0;
        end else begin
            par_q     <= par_d;
            par_err_q <= par_err_d;
        end
    end

    assign par     = par_q;
    assign par_err = par_err_q;

endmodule

// File: rtl/gp_data_reg.sv
// gp_data_reg: a DWIDTH-bit storage register with load enable, synchronous clear
// and a one-cycle change pulse.
// Optional macro GP_DATA_REG_PARITY_EN adds the ports d_par, par and par_err.
// Clear takes priority over load.
// chg is high for the cycle after any edge where q took a different value.
module gp_data_reg
    import gp_data_reg_pkg::*;
#(
    parameter int                DWIDTH  = DEF_DWIDTH,
    parameter logic [DWIDTH-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [DWIDTH-1:0] d,
    output logic [DWIDTH-1:0] q,
    output logic              chg
`ifdef GP_DATA_REG_PARITY_EN
    ,
    input  logic              d_par,
    output logic              par,
    output logic              par_err
`endif
);

    logic [DWIDTH-1:0] q_d;
    logic [DWIDTH-1:0] q_q;
    logic              chg_d;
    logic              chg_q;

    // Next-state selection: clear beats load, otherwise hold.
    // When en is low, d is not selected, so an unknown d cannot reach q.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = RST_VAL;
        end else if (en) begin
            q_d = d;
        end
        chg_d = (q_d != q_q);
    end

    // Storage and change flag; reset forces both immediately, regardless of clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= RST_VAL;
            chg_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            chg_q <= chg_d;
        end
    end

    assign q   = q_q;
    assign chg = chg_q;

`ifdef GP_DATA_REG_PARITY_EN
    logic load;
    assign load = en & ~clr;

    gp_data_reg_par #(
        .DWIDTH  (DWIDTH),
        .RST_VAL (RST_VAL)
    ) u_par (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .q_next  (q_d),
        .d       (d),
        .d_par   (d_par),
        .par     (par),
        .par_err (par_err)
    );
`endif

endmodule

// File: tb/tb_gp_data_reg.sv
// Scoreboard bench for gp_data_reg.
// The driver applies one operation per cycle at the falling edge and pushes the
// response predicted by a reference model.
// The monitor pops one expectation per rising edge and compares it with the outputs.
// Parity checks are included when GP_DATA_REG_PARITY_EN is defined.
module tb_gp_data_reg;
    import gp_data_reg_pkg::*;

    localparam int            W  = 8;
    localparam logic [W-1:0]  RV = '0;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         clr;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         chg;
`ifdef GP_DATA_REG_PARITY_EN
    logic         d_par;
    logic         par;
    logic         par_err;
`endif

    always #5 clk = ~clk;

    gp_data_reg #(
        .DWIDTH  (W),
        .RST_VAL (RV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clr     (clr),
        .d       (d),
        .q       (q),
        .chg     (chg)
`ifdef GP_DATA_REG_PARITY_EN
        ,
        .d_par   (d_par),
        .par     (par),
        .par_err (par_err)
`endif
    );

    typedef struct {
        op_e          op;
        logic [W-1:0] d;
        logic [W-1:0] q;
        logic         chg;
        logic         par;
        logic         perr;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    logic [W-1:0] model_q;
    int           checks = 0;
    int           errors = 0;
    int           txn    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One operation per cycle.
    // The model applies the rules directly: clear wins, load takes d, otherwise hold.
    task automatic drive(input logic e, input logic c, input logic [W-1:0] dv, input logic dp);
        exp_t         x;
        logic [W-1:0] nxt;
        @(negedge clk);
        en  = e;
        clr = c;
        d   = dv;
`ifdef GP_DATA_REG_PARITY_EN
        d_par = dp;
`endif
        if (c)      nxt = RV;
        else if (e) nxt = dv;
        else        nxt = model_q;
        x.op   = c ? OP_CLR : (e ? OP_LOAD : OP_IDLE);
        x.d    = dv;
        x.q    = nxt;
        x.chg  = (nxt != model_q);
        x.par  = ^nxt;
        x.perr = (e && !c) && (dp != ^dv);
        model_q = nxt;
        exp_q.push_back(x);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: one expectation per rising edge, sampled just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                txn++;
                $display("txn %0d op=%s d=%h q=%h chg=%b exp_q=%h exp_chg=%b",
                         txn, mon_e.op.name(), mon_e.d, q, chg, mon_e.q, mon_e.chg);
                check("q", 64'(q), 64'(mon_e.q));
                check("chg", 64'(chg), 64'(mon_e.chg));
`ifdef GP_DATA_REG_PARITY_EN
                check("par", 64'(par), 64'(mon_e.par));
                check("par_err", 64'(par_err), 64'(mon_e.perr));
`endif
            end
        end
    end

    // Global time limit on the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] dv;
        logic [W-1:0] stream_v [4];
        int           r;

        rst_n   = 1'b0;
        en      = 1'b0;
        clr     = 1'b0;
        d       = '0;
`ifdef GP_DATA_REG_PARITY_EN
        d_par   = 1'b0;
`endif
        model_q = RV;

        // Reset state while rst_n is held low.
        #12;
        check("rst_q", 64'(q), 64'(RV));
        check("rst_chg", 64'(chg), 64'd0);
`ifdef GP_DATA_REG_PARITY_EN
        check("rst_par", 64'(par), 64'(^RV));
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a cycle, with q holding A5.
        drive(1'b1, 1'b0, 8'hA5, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drain();
        @(negedge clk);
        check("pre_rst_q", 64'(q), 64'h A5);
        #2;
        rst_n = 1'b0;
        en    = 1'b1;
        d     = 8'hFF;
        #1;
        check("async_rst_q", 64'(q), 64'(RV));
        check("async_rst_chg", 64'(chg), 64'd0);
        @(posedge clk);
        #1;
        check("rst_hold_q", 64'(q), 64'(RV));
        check("rst_hold_chg", 64'(chg), 64'd0);
        @(negedge clk);
        en      = 1'b0;
        rst_n   = 1'b1;
        model_q = RV;

        // Load followed by an idle cycle with a different d.
        drive(1'b1, 1'b0, 8'h3C, 1'b0);
        drive(1'b0, 1'b0, 8'hFF, 1'b1);
        // Clear overrides a simultaneous load; a repeated clear gives no change.
        drive(1'b1, 1'b1, 8'h77, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        // Loading the value already stored gives no change.
        drive(1'b1, 1'b0, 8'h55, 1'b0);
        drive(1'b1, 1'b0, 8'h55, 1'b0);
        // Continuous streaming through the boundary values.
        stream_v[0] = 8'h01;
        stream_v[1] = 8'h02;
        stream_v[2] = 8'h80;
        stream_v[3] = 8'hFF;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, stream_v[i], 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        // An unknown d with en low must leave q unchanged.
        drive(1'b0, 1'b0, 'x, 1'b0);
        // Parity: a correct d_par, then a wrong one (q still loads).
        drive(1'b1, 1'b0, 8'h07, 1'b1);
        drive(1'b1, 1'b0, 8'h03, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b0);

        // Randomized operations.
        for (int i = 0; i < 300; i++) begin
            r  = int'($urandom_range(0, 9));
            dv = W'($urandom);
            if (r == 8) dv = model_q;
            drive(r < 7, r >= 8 && ($urandom_range(0, 1) == 1), dv, 1'($urandom));
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gp_data_reg.md
Name: gp_data_reg

Overview:
- General-purpose DWIDTH-bit storage register with load enable and synchronous clear.
- A leaf block: it sits behind the team's register interface wrapper and is driven by the quiet and verbose register testers.
- The output always reflects the last value loaded since reset or clear.
- A status pulse flags every cycle in which the stored value changes.

Parameters:
- DWIDTH, 8, data width in bits; legal range 1..64.
- RST_VAL, '0 (DWIDTH bits), value loaded by asynchronous reset and by synchronous clear.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  load enable; when high, d is captured on the next rising edge.
- clr  input  1  synchronous clear; when high, q takes RST_VAL on the next rising edge.
- d  input  DWIDTH  data to load.
- q  output  DWIDTH  registered stored value.
- chg  output  1  registered pulse, high for one cycle after any edge where q changed value.

Behaviour:
- Reset: rst_n low asynchronously forces q=RST_VAL and chg=0, independent of clk. Both hold while rst_n is low.
- Reset release is synchronous in effect: the first capture happens on the first rising edge with rst_n high.
- Priority at each rising edge, with rst_n high:
  - clr=1: q<=RST_VAL. clr overrides en.
  - else en=1: q<=d.
  - else q holds.
- Latency: one cycle from en/d sampled to q. q is never combinational from d.
- chg: at each edge, chg<=1 iff the next q differs from the current q; otherwise chg<=0.
  - A load of the same value gives chg=0.
  - A clear when q already equals RST_VAL gives chg=0.
- X/Z on d with en=0 must not affect q.
- Reset asserted mid-operation overrides any pending en/clr. q=RST_VAL immediately; no partial update.
- Width rules: d and q are both exactly DWIDTH bits wide; there is no truncation or extension.
- No handshake. en may stay high continuously, in which case q follows d with one-cycle delay.

Optional Feature:
- Macro: GP_DATA_REG_PARITY_EN.
- Defined:
  - Adds output port par (1 bit): the even-parity bit of the stored value, registered alongside q. par = XOR of all bits of q, updated on the same edge as q.
  - Reset and clear set par to the parity of RST_VAL.
  - Adds input d_par (1 bit): expected parity of d. On a load, if d_par does not equal the XOR of d, the output par_err (1 bit) pulses high for one cycle. q is still loaded.
- Undefined:
  - Ports par, d_par and par_err do not exist.
  - No parity logic is synthesised.

Decomposition:
- Package gp_data_reg_pkg:
  - localparam DEF_DWIDTH=8.
  - function automatic even_par (shared with the testers' scoreboards).
  - typedef for the op encoding used by benches: enum {OP_IDLE, OP_LOAD, OP_CLR}.
- Optional sub-module gp_data_reg_par: a parity generator/checker, instantiated only under GP_DATA_REG_PARITY_EN.
- The core register has no further split.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with q=8'hA5 -> q=8'h00 and chg=0 immediately, before the next clk edge.
- Load: en=1, d=8'h3C for one edge -> q=8'h3C one cycle later, chg=1 for that one cycle. Then en=0, d=8'hFF -> q holds 8'h3C, chg=0.
- Clear priority: q=8'h3C; clr=1, en=1, d=8'h77 -> q=8'h00, chg=1. A repeated clr -> q=8'h00, chg=0.
- Same-value load: q=8'h55; en=1, d=8'h55 -> q=8'h55, chg=0.
- Back-to-back streaming: en=1 held, d=8'h01,8'h02,8'h80,8'hFF on successive edges -> q follows one cycle later and chg=1 on each of the four cycles. Boundary values 8'h00/8'hFF are covered.
- Parity (GP_DATA_REG_PARITY_EN defined):
  - Load d=8'h07 with d_par=1 -> par=1, par_err=0.
  - Load d=8'h03 with d_par=1 -> q=8'h03, par=0, par_err=1 for one cycle.
